cnn_row_feeder: RTL and testbench
=================================

CNN_ROW_FEEDER -- requirements
Module: cnn_row_feeder

Interface
REQ-001 SHALL have parameter H, default 24: rows per frame.
REQ-002 SHALL have parameter W, default 24: pixels per row.
REQ-003 SHALL have parameter DATA_BITS, default 8: bits per pixel.
REQ-004 SHALL have parameter ROW_GAP, default 64: idle cycles inserted after each emitted row.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port s_data, input, DATA_BITS: pixel stream data.
REQ-008 SHALL have port s_valid, input, 1: pixel present.
REQ-009 SHALL have port s_ready, output, 1: feeder accepts a pixel; a transfer occurs when s_valid and s_ready are both high.
REQ-010 SHALL have port row_data, output, W*DATA_BITS: packed row driving the CNN input_data.
REQ-011 SHALL have port row_valid, output, 1: one-cycle row strobe driving the CNN buffer_1_valid_i.
REQ-012 SHALL have port dense_valid, input, 1: CNN result strobe.
REQ-013 SHALL have port frame_done, output, 1: one-cycle end-of-frame pulse.
REQ-014 SHALL have port row_idx, output, clog2(H): index of the row currently being filled.

Function
REQ-015 SHALL implement states FILL, SEND, GAP and WAIT_RES.
REQ-016 FILL: s_ready=1; the c-th accepted pixel (c=0..W-1) SHALL be stored at bits [c*DATA_BITS +: DATA_BITS].
REQ-017 FILL SHALL go to SEND on the transfer of pixel W-1.
REQ-018 SEND SHALL last exactly one cycle with row_valid=1 and s_ready=0, so row_valid rises the cycle after the last pixel transfer.
REQ-019 On entry to SEND, row_data SHALL load from the packing register and hold until the next SEND.
REQ-020 After SEND: go to GAP if ROW_GAP>0, otherwise FILL; with FRAME_WAIT_EN, the row H-1 case SHALL go to WAIT_RES instead.
REQ-021 GAP SHALL hold s_ready=0 for exactly ROW_GAP cycles, then go to FILL.
REQ-022 row_idx SHALL increment in SEND and wrap from H-1 to 0.
REQ-023 The pixel column counter SHALL reset to 0 in SEND.
REQ-024 WAIT_RES: s_ready=0; a sampled dense_valid=1 SHALL pulse frame_done next cycle and go to FILL.
REQ-025 dense_valid in any state other than WAIT_RES SHALL be ignored.
REQ-026 s_valid=0 in FILL SHALL stall with no state or counter change; a gap of any length is legal.
REQ-027 row_valid and frame_done SHALL never be high for two consecutive cycles.

Reset
REQ-028 resetn low SHALL asynchronously force FILL, counters=0, row_data=0, row_valid=0, frame_done=0 and s_ready=0.
REQ-029 s_ready SHALL rise the first cycle after release.
REQ-030 Reset mid-row or mid-frame SHALL discard partial data; no row_valid is emitted for it.

Configuration
REQ-031 Macro CNN_FEEDER_FRAME_WAIT_EN defined: after row H-1 the feeder enters WAIT_RES and blocks input until dense_valid.
REQ-032 Macro not defined: WAIT_RES is not built; frame_done pulses in the same cycle as row_valid of row H-1; dense_valid is unused.

Structure
REQ-033 Package cnn_feed_pkg SHALL hold the state enum and the defaults for H, W, DATA_BITS and ROW_GAP.
REQ-034 Pixel packing SHALL be sub-module cnn_row_packer (column counter plus packing register).

Verification
REQ-035 H=W=24, ROW_GAP=64, pixels 0..23 continuous -> row_valid one cycle after the 24th transfer; row_data byte c = c; s_ready low for 65 cycles.
REQ-036 s_valid toggling 1/0 -> the row is still assembled in order; row_valid rises after the 24th accepted pixel.
REQ-037 Full frame (576 pixels) with the macro on -> 24 row_valid pulses, s_ready stays low until dense_valid; frame_done one cycle after dense_valid; row_idx=0.
REQ-038 Same frame with the macro off -> frame_done coincides with the 24th row_valid; the next frame is accepted after 64 gap cycles.
REQ-039 resetn low after 10 pixels of row 5 -> all outputs 0 immediately; the next 24 pixels form row 0.
REQ-040 ROW_GAP=0, dense_valid pulsed during FILL -> no GAP cycles; dense_valid ignored; frame_done stays 0 until WAIT_RES.

Source files
------------

// File: rtl/cnn_feed_pkg.sv
// cnn_feed_pkg
// Shared defaults and state encoding for the CNN row feeder.
//   H_DEF / W_DEF     : frame geometry (rows, pixels per row)
//   DATA_BITS_DEF     : pixel width
//   ROW_GAP_DEF       : idle cycles inserted after each emitted row
//   feed_state_e      : feeder FSM states
package cnn_feed_pkg;

  localparam int H_DEF         = 24;
  localparam int W_DEF         = 24;
  localparam int DATA_BITS_DEF = 8;
  localparam int ROW_GAP_DEF   = 64;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SEND     = 2'd1,
    GAP      = 2'd2,
    WAIT_RES = 2'd3
  } feed_state_e;

endpackage

// File: rtl/cnn_row_packer.sv
// cnn_row_packer
// Column counter plus packing register; assembles W pixels into one row.
// Ports:
//   clk, resetn : clock, async active-low reset
//   s_data      : incoming pixel
//   xfer        : pixel accepted this cycle
//   clear       : restart the column counter (row emitted)
//   last        : this transfer is column W-1
//   pack_nxt    : packing register including this cycle's pixel, so the
//                 owner can capture a complete row on the final transfer
module cnn_row_packer
  import cnn_feed_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_BITS-1:0]     s_data,
  input  logic                     xfer,
  input  logic                     clear,
  output logic                     last,
  output logic [W*DATA_BITS-1:0]   pack_nxt
);

  localparam int COL_W = (W > 1) ? $clog2(W) : 1;

  logic [COL_W-1:0]       col;
  logic [W*DATA_BITS-1:0] pack;

  assign last = xfer && (col == COL_W'(W - 1));

  always_comb begin
    pack_nxt = pack;
    if (xfer) pack_nxt[col*DATA_BITS +: DATA_BITS] = s_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col  <= '0;
      pack <= '0;
    end else begin
      pack <= pack_nxt;
      if (clear)     col <= '0;
      else if (xfer) col <= last ? '0 : col + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_row_feeder.sv
// cnn_row_feeder
// Collects a pixel stream into packed rows for the CNN and paces it with an
// idle gap after every row.
// Optional build macro: CNN_FEEDER_FRAME_WAIT_EN -- after the last row of a
// frame, hold input off until the CNN strobes dense_valid.
// Ports:
//   clk, resetn           : clock, async active-low reset
//   s_data/s_valid/s_ready: pixel stream handshake
//   row_data/row_valid    : packed row and its one-cycle strobe
//   dense_valid           : CNN result strobe (frame-wait build only)
//   frame_done            : one-cycle end-of-frame pulse
//   row_idx               : row currently being filled
//
// state    | meaning
// FILL     | accepting pixels into the packer
// SEND     | one cycle, row_valid high, row index advances
// GAP      | ROW_GAP idle cycles, input held off
// WAIT_RES | frame end, input held off until dense_valid
module cnn_row_feeder
  import cnn_feed_pkg::*;
#(
  parameter int H         = H_DEF,
  parameter int W         = W_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ROW_GAP   = ROW_GAP_DEF,
  localparam int IDX_W    = (H > 1) ? $clog2(H) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_BITS-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [W*DATA_BITS-1:0] row_data,
  output logic                   row_valid,
  input  logic                   dense_valid,
  output logic                   frame_done,
  output logic [IDX_W-1:0]       row_idx
);

  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  feed_state_e            state, state_nxt;
  logic                   armed;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   xfer;
  logic                   last;
  logic                   last_row;
  logic [W*DATA_BITS-1:0] pack_nxt;

  // armed keeps s_ready low while in reset and for the release edge
  assign s_ready   = armed && (state == FILL);
  assign xfer      = s_valid && s_ready;
  assign row_valid = (state == SEND);
  assign last_row  = (row_idx == IDX_W'(H - 1));

  cnn_row_packer #(
    .W         (W),
    .DATA_BITS (DATA_BITS)
  ) u_packer (
    .clk      (clk),
    .resetn   (resetn),
    .s_data   (s_data),
    .xfer     (xfer),
    .clear    (state == SEND),
    .last     (last),
    .pack_nxt (pack_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= FILL;
      armed    <= 1'b0;
      gap_cnt  <= '0;
      row_idx  <= '0;
      row_data <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (last) row_data <= pack_nxt;
      if (state == SEND) begin
        gap_cnt <= GAP_LOAD;
        row_idx <= last_row ? '0 : row_idx + 1'b1;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (last) state_nxt = SEND;
      SEND: begin
`ifdef CNN_FEEDER_FRAME_WAIT_EN
        if (last_row)         state_nxt = WAIT_RES;
        else if (ROW_GAP > 0) state_nxt = GAP;
        else                  state_nxt = FILL;
`else
        if (ROW_GAP > 0) state_nxt = GAP;
        else             state_nxt = FILL;
`endif
      end
      GAP: if (gap_cnt == '0) state_nxt = FILL;
`ifdef CNN_FEEDER_FRAME_WAIT_EN
      WAIT_RES: if (dense_valid) state_nxt = FILL;
`endif
      default: state_nxt = FILL;
    endcase
  end

`ifdef CNN_FEEDER_FRAME_WAIT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) frame_done <= 1'b0;
    else         frame_done <= (state == WAIT_RES) && dense_valid;
  end
`else
  // without the wait, the frame ends with the strobe of the last row
  logic unused_dense;
  assign unused_dense = dense_valid;
  assign frame_done   = row_valid && last_row;
`endif

endmodule

// File: tb/tb_cnn_row_feeder.sv
module tb_cnn_row_feeder;

  localparam int TH = 24;
  localparam int TW = 24;
  localparam int TGAP = 64;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [191:0] row_data;
  logic         row_valid;
  logic         dense_valid;
  logic         frame_done;
  logic [4:0]   row_idx;

  logic [7:0]   s_data1;
  logic         s_valid1;
  logic         s_ready1;
  logic [31:0]  row_data1;
  logic         row_valid1;
  logic         dense_valid1;
  logic         frame_done1;
  logic [0:0]   row_idx1;

  int n_chk = 0;
  int n_bad = 0;

  bit rv_prev = 0, fd_prev = 0, dbl_seen = 0;

  always #5 clk = ~clk;

  cnn_row_feeder dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .dense_valid (dense_valid),
    .frame_done  (frame_done),
    .row_idx     (row_idx)
  );

  cnn_row_feeder #(.H(2), .W(4), .DATA_BITS(8), .ROW_GAP(0)) dut_nogap (
    .clk         (clk),
    .resetn      (resetn),
    .s_data      (s_data1),
    .s_valid     (s_valid1),
    .s_ready     (s_ready1),
    .row_data    (row_data1),
    .row_valid   (row_valid1),
    .dense_valid (dense_valid1),
    .frame_done  (frame_done1),
    .row_idx     (row_idx1)
  );

  always @(negedge clk) begin
    if ((row_valid && rv_prev) || (frame_done && fd_prev)) dbl_seen = 1;
    rv_prev = row_valid;
    fd_prev = frame_done;
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 300) begin
      step();
      n++;
    end
    if (!s_ready) chk("ready_timeout", 192'(s_ready), 192'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] base, input bit toggle, output logic [191:0] exp);
    exp = '0;
    for (int c = 0; c < TW; c++) begin
      if (toggle) begin
        s_valid = 1'b0;
        s_data  = 8'hee;
        step();
      end
      push(base + 8'(c));
      exp[c*8 +: 8] = base + 8'(c);
      if (c == TW - 2) chk("rv_early", 192'(row_valid), 192'd0);
    end
  endtask

  task automatic finish_row(input logic [191:0] exp, input int idx, input bit last);
    int n;
    bit any_ready;
    chk("row_valid", 192'(row_valid), 192'd1);
    chk("row_data", row_data, exp);
    chk("row_idx_send", 192'(row_idx), 192'(idx));
    chk("ready_send", 192'(s_ready), 192'd0);
`ifdef CNN_FEEDER_FRAME_WAIT_EN
    chk("fd_send", 192'(frame_done), 192'd0);
    if (last) begin
      any_ready = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (s_ready) any_ready = 1;
        if (frame_done) any_ready = 1;
      end
      chk("wait_block", 192'(any_ready), 192'd0);
      chk("idx_wrap", 192'(row_idx), 192'd0);
      dense_valid = 1'b1;
      step();
      dense_valid = 1'b0;
      chk("fd_pulse", 192'(frame_done), 192'd1);
      chk("ready_after_res", 192'(s_ready), 192'd1);
      step();
      chk("fd_fall", 192'(frame_done), 192'd0);
      return;
    end
`else
    chk("fd_send", 192'(frame_done), 192'(last));
`endif
    n = 1;
    while (n < 500) begin
      step();
      if (s_ready) break;
      n++;
    end
    chk("gap_len", 192'(n), 192'(TGAP + 1));
    chk("idx_next", 192'(row_idx), 192'((idx + 1) % TH));
  endtask

  initial begin
    logic [191:0] exp;
    resetn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    dense_valid = 1'b0;
    s_valid1 = 1'b0;
    s_data1 = '0;
    dense_valid1 = 1'b0;
    step();
    step();
    chk("rst_ready", 192'(s_ready), 192'd0);
    chk("rst_rv", 192'(row_valid), 192'd0);
    chk("rst_data", row_data, 192'd0);
    chk("rst_fd", 192'(frame_done), 192'd0);
    chk("rst_idx", 192'(row_idx), 192'd0);
    resetn = 1'b1;
    step();
    chk("ready_rise", 192'(s_ready), 192'd1);

    // row 0, continuous pixels 0..23
    send_row(8'h00, 0, exp);
    finish_row(exp, 0, 0);

    // row 1, s_valid toggling, dense_valid asserted outside WAIT_RES
    dense_valid = 1'b1;
    send_row(8'h40, 1, exp);
    dense_valid = 1'b0;
    finish_row(exp, 1, 0);

    // rest of the frame
    for (int r = 2; r < TH; r++) begin
      send_row(8'(r * 8), 0, exp);
      finish_row(exp, r, r == TH - 1);
    end

    // rows 0..4 then a partial row 5, reset mid-row
    for (int r = 0; r < 5; r++) begin
      send_row(8'h80 + 8'(r), 0, exp);
      finish_row(exp, r, 0);
    end
    for (int c = 0; c < 10; c++) push(8'ha0 + 8'(c));
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready", 192'(s_ready), 192'd0);
    chk("mid_rst_rv", 192'(row_valid), 192'd0);
    chk("mid_rst_data", row_data, 192'd0);
    chk("mid_rst_idx", 192'(row_idx), 192'd0);
    chk("mid_rst_fd", 192'(frame_done), 192'd0);
    step();
    resetn = 1'b1;
    step();
    chk("ready_rise2", 192'(s_ready), 192'd1);
    send_row(8'h10, 0, exp);
    finish_row(exp, 0, 0);

    // ROW_GAP=0 instance, H=2 W=4
    s_valid1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s_data1 = 8'(c);
      dense_valid1 = (c == 1);
      step();
    end
    dense_valid1 = 1'b0;
    s_valid1 = 1'b0;
    chk("ng_rv0", 192'(row_valid1), 192'd1);
    chk("ng_data0", 192'(row_data1), 192'h03020100);
    chk("ng_ready_send", 192'(s_ready1), 192'd0);
    chk("ng_fd0", 192'(frame_done1), 192'd0);
    step();
    chk("ng_no_gap", 192'(s_ready1), 192'd1);
    chk("ng_rv_fall", 192'(row_valid1), 192'd0);
    s_valid1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s_data1 = 8'h10 + 8'(c);
      dense_valid1 = (c == 2);
      step();
      if (c == 2) chk("ng_dense_ignored", 192'(frame_done1), 192'd0);
    end
    dense_valid1 = 1'b0;
    s_valid1 = 1'b0;
    chk("ng_rv1", 192'(row_valid1), 192'd1);
    chk("ng_data1", 192'(row_data1), 192'h13121110);
    chk("ng_idx1", 192'(row_idx1), 192'd1);
`ifdef CNN_FEEDER_FRAME_WAIT_EN
    chk("ng_fd1", 192'(frame_done1), 192'd0);
    step();
    chk("ng_wait_ready", 192'(s_ready1), 192'd0);
    chk("ng_wrap", 192'(row_idx1), 192'd0);
    dense_valid1 = 1'b1;
    step();
    dense_valid1 = 1'b0;
    chk("ng_fd_pulse", 192'(frame_done1), 192'd1);
`else
    chk("ng_fd1", 192'(frame_done1), 192'd1);
    step();
    chk("ng_ready_next", 192'(s_ready1), 192'd1);
    chk("ng_fd_fall", 192'(frame_done1), 192'd0);
    chk("ng_wrap", 192'(row_idx1), 192'd0);
`endif
    step();
    chk("no_double_pulse", 192'(dbl_seen), 192'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
